// File: rtl/estagiodivisao.sv
// Single restoring-division step: shift in one dividend bit, subtract the divisor if it fits.
module estagiodivisao (
  input  logic [3:0] Resto_anterior,
  input  logic       D_bit,
  input  logic [3:0] B,
  output logic [3:0] Resto_novo,
  output logic       Q_bit
);

  logic [3:0] parcial;

  // Resto_anterior[3] is dropped; callers guarantee it is zero.
  always_comb begin
    parcial    = {Resto_anterior[2:0], D_bit};
    Q_bit      = (parcial >= B);
    Resto_novo = Q_bit ? 4'(parcial - B) : parcial;
  end

endmodule

// File: rtl/divisor_sequencial_ctrl.sv
// Sequential 4-bit unsigned restoring divider: iterates one estagiodivisao stage
// MSB-first over the dividend, one bit per clock, with start/busy/done handshake.
module divisor_sequencial_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quociente,
  output logic [WIDTH-1:0] Resto,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH != 4) begin : g_width_check
    $error("divisor_sequencial_ctrl: only WIDTH=4 is supported");
  end

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] b_reg, b_nxt;
  logic [WIDTH-1:0] r_reg, r_nxt;
  logic [WIDTH-1:0] q_sh, q_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;
  logic [WIDTH-1:0] quo_nxt, resto_nxt;

  logic [WIDTH-1:0] resto_novo;
  logic             q_bit;

  estagiodivisao u_stage (
    .Resto_anterior (r_reg),
    .D_bit          (a_reg[count]),
    .B              (b_reg),
    .Resto_novo     (resto_novo),
    .Q_bit          (q_bit)
  );

  // Next-state and datapath update
  always_comb begin
    state_nxt    = state;
    a_nxt        = a_reg;
    b_nxt        = b_reg;
    r_nxt        = r_reg;
    q_nxt        = q_sh;
    count_nxt    = count;
    done_nxt     = 1'b0;
    quo_nxt      = Quociente;
    resto_nxt    = Resto;
    div_zero_nxt = div_zero;

    case (state)
      S_IDLE: begin
        if (start) begin
          a_nxt     = A;
          b_nxt     = B;
          r_nxt     = '0;
          q_nxt     = '0;
          count_nxt = CW'(WIDTH - 1);
          if (B == '0) begin
            // Division by zero resolves immediately without iterating.
            state_nxt    = S_DONE;
            done_nxt     = 1'b1;
            quo_nxt      = '1;
            resto_nxt    = A;
            div_zero_nxt = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_nxt     = resto_novo;
        q_nxt     = {q_sh[WIDTH-2:0], q_bit};
        count_nxt = CW'(count - CW'(1));
        if (count == '0) begin
          state_nxt    = S_DONE;
          done_nxt     = 1'b1;
          quo_nxt      = {q_sh[WIDTH-2:0], q_bit};
          resto_nxt    = resto_novo;
          div_zero_nxt = 1'b0;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      q_sh      <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Quociente <= '0;
      Resto     <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      a_reg     <= a_nxt;
      b_reg     <= b_nxt;
      r_reg     <= r_nxt;
      q_sh      <= q_nxt;
      count     <= count_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      Quociente <= quo_nxt;
      Resto     <= resto_nxt;
      div_zero  <= div_zero_nxt;
    end
  end

endmodule

// File: tb/tb_divisor_sequencial_ctrl.sv
// Scoreboard bench for divisor_sequencial_ctrl: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_divisor_sequencial_ctrl;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B;
  logic       busy, done, div_zero;
  logic [3:0] Quociente, Resto;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  divisor_sequencial_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Quociente (Quociente),
    .Resto     (Resto),
    .div_zero  (div_zero)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.dz = 1'b1;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quociente", int'(Quociente), int'(e.q));
        check("resto",     int'(Resto),     int'(e.r));
        check("div_zero",  int'(div_zero),  int'(e.dz));
      end
    end
  end

  // Called shortly after a posedge while the DUT is idle; returns idle again.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    exp_q.push_back(model(int'(a), int'(b)));
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (b != 4'd0) repeat (5) @(posedge clk);
    else           repeat (1) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quo",  int'(Quociente), 0);
    check("rst_resto", int'(Resto), 0);
    check("rst_dz",   int'(div_zero), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 13/4 with cycle-accurate busy/done timing
    exp_q.push_back('{q: 4'd3, r: 4'd1, dz: 1'b0});
    A = 4'd13; B = 4'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_busy_run", int'(busy), 1);
      check("t1_done_run", int'(done), 0);
    end
    @(negedge clk);
    check("t1_busy_end", int'(busy), 0);
    check("t1_done_end", int'(done), 1);
    @(posedge clk); #1;
    check("t1_hold_quo", int'(Quociente), 3);

    issue(4'd7, 4'd9);
    issue(4'd15, 4'd1);
    issue(4'd15, 4'd15);

    // Divide by zero: no busy, done right after the start edge
    exp_q.push_back('{q: 4'd15, r: 4'd10, dz: 1'b1});
    A = 4'd10; B = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("dz_busy", int'(busy), 0);
    check("dz_done", int'(done), 1);
    @(posedge clk); #1;
    issue(4'd6, 4'd3);

    // Start during RUN is ignored
    exp_q.push_back('{q: 4'd2, r: 4'd2, dz: 1'b0});
    d0 = done_cnt;
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    A = 4'd1; B = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ign_done_pulses", done_cnt - d0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("ign_no_extra", done_cnt - d0, 1);

    // Asynchronous reset mid-RUN
    A = 4'd9; B = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",  int'(busy), 0);
    check("arst_done",  int'(done), 0);
    check("arst_quo",   int'(Quociente), 0);
    check("arst_resto", int'(Resto), 0);
    check("arst_dz",    int'(div_zero), 0);
    d0 = done_cnt;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_no_done", done_cnt - d0, 0);
    issue(4'd9, 4'd2);

    // Exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue(4'(a), 4'(b));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
